change_dispenser: RTL
=====================

// Module: change_dispenser
// PURPOSE
//   Consumer end of the change interface: takes the signed change value from the datapath
//   (units of 1/8 dollar; $1=8, $0.50=4, $0.25=2) and pays it out one coin at a time.
//   Greedy decomposition, one coin per req/ack handshake with the coin hopper.
//   Tracks the hopper inventory and reports any amount it could not pay.
// PARAMETERS
//   UNIT_1      8    value of a $1 coin in 1/8-dollar units
//   UNIT_05     4    value of a $0.50 coin
//   UNIT_025    2    value of a $0.25 coin
//   INIT_1      20   $1 inventory after reset (8-bit)
//   INIT_05     10   $0.50 inventory after reset
//   INIT_025    10   $0.25 inventory after reset
//   TIMEOUT     255  cycles out_eject_* may stay high without in_hopper_ack before FAULT
// PORTS
//   in_clka          in   1   clock, rising edge
//   in_restart_n     in   1   asynchronous reset, active low
//   in_load          in   1   1-cycle strobe: start paying in_change (sampled in IDLE only)
//   in_change        in   16  signed change, 1/8-dollar units
//   in_refill        in   1   1-cycle strobe: add in_refill_* to the inventories
//   in_refill_1      in   8   $1 coins added
//   in_refill_05     in   8   $0.50 coins added
//   in_refill_025    in   8   $0.25 coins added
//   in_hopper_ack    in   1   hopper has ejected the requested coin (4-phase)
//   out_eject_1      out  1   request: eject one $1 coin
//   out_eject_05     out  1   request: eject one $0.50 coin
//   out_eject_025    out  1   request: eject one $0.25 coin
//   out_busy         out  1   payout in progress (high in every state except IDLE and FAULT)
//   out_done         out  1   1-cycle pulse: payout finished
//   out_short        out  1   last payout left a nonzero remainder; held until next accepted load
//   out_short_amt    out  16  unpaid remainder of the last payout, 1/8 units
//   out_error        out  1   hopper timeout; sticky until reset
//   out_inv_1/05/025 out  8   current inventories
// BEHAVIOUR
//   Reset (async, in_restart_n=0): state IDLE; all out_eject_*, busy, done, short and error = 0;
//     short_amt = 0; inventories = INIT_*. Reset mid-payout drops the request immediately.
//   States: IDLE, SEL, EJECT, REL, DONE, FAULT. All outputs are registered.
//   IDLE: in_load=1 -> rem <= (in_change<0 ? 0 : in_change); short <= 0; go SEL.
//     in_load in any other state is ignored.
//   SEL (one cycle), pick the first coin that fits, in order $1, $0.50, $0.25:
//     rem>=UNIT_1 and inv_1>0, else rem>=UNIT_05 and inv_05>0, else rem>=UNIT_025 and inv_025>0.
//     Coin found -> assert exactly one out_eject_*; go EJECT. No coin fits -> go DONE.
//   EJECT: hold the request. When in_hopper_ack=1: drop the request, decrement that inventory,
//     rem -= coin value, go REL. TIMEOUT cycles without ack: drop the request, error <= 1, go FAULT.
//   REL: wait for in_hopper_ack=0, then go SEL (no timeout here).
//   DONE: out_done=1 for exactly one cycle; short_amt <= rem; short <= (rem!=0); go IDLE.
//   FAULT: no requests, busy=0; ignores in_load; leaves only on reset.
//   Latency: load sampled at edge N -> busy at N+1 -> first request at N+2.
//     Change <= 0: done pulse at N+2 with no coins paid.
//   Odd remainder (a 1/8 unit) can never be paid and ends up in short_amt.
//   Refill: accepted in every state; each inventory saturates at 255. If a refill and a coin
//     decrement hit the same cycle, the net result (inv + refill - 1, saturated) is applied.
//   Exactly one out_eject_* at a time; a request never changes while it is asserted.
// TESTING
//   Inventories 20/10/10, load 14 -> ejects $1, $0.50, $0.25 in that order; done; short=0; inv 19/9/9.
//   Load -6, then load 0 -> one done pulse 2 cycles after each load; no out_eject_*; short=0.
//   Load 13 -> $1, $0.50 paid; done; short=1, short_amt=1.
//   inv_1=0, load 16 -> four $0.50 coins; inv_05 drops 10->6; short=0.
//   Hopper never acks, load 8 -> out_eject_1 high for 255 cycles then low; error=1; later loads ignored.
//   Reset while out_eject_05 is high -> request low at once; inventories back to 20/10/10; state IDLE.

Source files
------------

// File: rtl/change_dispenser_if.sv
// Change payout interface: datapath/hopper side (master) and dispenser side (slave).
interface change_dispenser_if;
    logic               in_load;
    logic signed [15:0] in_change;
    logic               in_refill;
    logic [7:0]         in_refill_1;
    logic [7:0]         in_refill_05;
    logic [7:0]         in_refill_025;
    logic               in_hopper_ack;
    logic               out_eject_1;
    logic               out_eject_05;
    logic               out_eject_025;
    logic               out_busy;
    logic               out_done;
    logic               out_short;
    logic [15:0]        out_short_amt;
    logic               out_error;
    logic [7:0]         out_inv_1;
    logic [7:0]         out_inv_05;
    logic [7:0]         out_inv_025;

    modport master (
        output in_load, in_change, in_refill, in_refill_1, in_refill_05, in_refill_025,
               in_hopper_ack,
        input  out_eject_1, out_eject_05, out_eject_025, out_busy, out_done, out_short,
               out_short_amt, out_error, out_inv_1, out_inv_05, out_inv_025
    );

    modport slave (
        input  in_load, in_change, in_refill, in_refill_1, in_refill_05, in_refill_025,
               in_hopper_ack,
        output out_eject_1, out_eject_05, out_eject_025, out_busy, out_done, out_short,
               out_short_amt, out_error, out_inv_1, out_inv_05, out_inv_025
    );
endinterface

// File: rtl/change_dispenser.sv
// Pays a signed change amount (1/8-dollar units) greedily, one coin per 4-phase hopper
// handshake, while tracking coin inventories and reporting any unpaid remainder.
module change_dispenser #(
    parameter int UNIT_1   = 8,
    parameter int UNIT_05  = 4,
    parameter int UNIT_025 = 2,
    parameter int INIT_1   = 20,
    parameter int INIT_05  = 10,
    parameter int INIT_025 = 10,
    parameter int TIMEOUT  = 255
) (
    input logic               in_clka,
    input logic               in_restart_n,
    change_dispenser_if.slave cif
);
    localparam logic [15:0] U1       = 16'(UNIT_1);
    localparam logic [15:0] U05      = 16'(UNIT_05);
    localparam logic [15:0] U025     = 16'(UNIT_025);
    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, SEL, EJECT, REL, DONE, FAULT} state_t;
    typedef enum logic [1:0] {COIN_NONE, COIN_1, COIN_05, COIN_025} coin_t;

    state_t      state, state_nxt;
    coin_t       coin, coin_nxt;
    logic [15:0] rem, rem_nxt;
    logic [7:0]  tmo_cnt, tmo_nxt;
    logic [7:0]  inv_1, inv_05, inv_025;
    logic        dec_1, dec_05, dec_025;
    logic        paid;

    function automatic logic [15:0] coin_value(input coin_t c);
        case (c)
            COIN_1:   return U1;
            COIN_05:  return U05;
            COIN_025: return U025;
            default:  return 16'd0;
        endcase
    endfunction

    // Refill and payout may land in the same cycle; the net count saturates at 255.
    function automatic logic [7:0] inv_update(input logic [7:0] inv, input logic [7:0] add,
                                              input logic dec);
        logic [9:0] sum;
        sum = {2'b00, inv} + {2'b00, add} - {9'd0, dec};
        return (sum > 10'd255) ? 8'd255 : sum[7:0];
    endfunction

    assign paid    = (state == EJECT) && cif.in_hopper_ack;
    assign dec_1   = paid && (coin == COIN_1);
    assign dec_05  = paid && (coin == COIN_05);
    assign dec_025 = paid && (coin == COIN_025);

    always_ff @(posedge in_clka or negedge in_restart_n) begin
        if (!in_restart_n) begin
            state   <= IDLE;
            coin    <= COIN_NONE;
            tmo_cnt <= 8'd0;
        end else begin
            state   <= state_nxt;
            coin    <= coin_nxt;
            tmo_cnt <= tmo_nxt;
        end
    end

    always_ff @(posedge in_clka) begin
        rem <= rem_nxt;
    end

    always_comb begin
        state_nxt = state;
        coin_nxt  = coin;
        rem_nxt   = rem;
        tmo_nxt   = tmo_cnt;
        case (state)
            IDLE: begin
                if (cif.in_load) begin
                    rem_nxt   = (cif.in_change < 16'sd0) ? 16'd0 : unsigned'(cif.in_change);
                    state_nxt = SEL;
                end
            end
            SEL: begin
                tmo_nxt = 8'd0;
                if (rem >= U1 && inv_1 != 8'd0)          coin_nxt = COIN_1;
                else if (rem >= U05 && inv_05 != 8'd0)   coin_nxt = COIN_05;
                else if (rem >= U025 && inv_025 != 8'd0) coin_nxt = COIN_025;
                else                                     coin_nxt = COIN_NONE;
                state_nxt = (coin_nxt == COIN_NONE) ? DONE : EJECT;
            end
            EJECT: begin
                if (cif.in_hopper_ack) begin
                    rem_nxt   = rem - coin_value(coin);
                    state_nxt = REL;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = FAULT;
                end else begin
                    tmo_nxt = tmo_cnt + 8'd1;
                end
            end
            REL:     if (!cif.in_hopper_ack) state_nxt = SEL;
            DONE:    state_nxt = IDLE;
            FAULT:   state_nxt = FAULT;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs: each follows the state one cycle later, so a request holds its coin.
    always_ff @(posedge in_clka or negedge in_restart_n) begin
        if (!in_restart_n) begin
            inv_1             <= 8'(INIT_1);
            inv_05            <= 8'(INIT_05);
            inv_025           <= 8'(INIT_025);
            cif.out_eject_1   <= 1'b0;
            cif.out_eject_05  <= 1'b0;
            cif.out_eject_025 <= 1'b0;
            cif.out_busy      <= 1'b0;
            cif.out_done      <= 1'b0;
            cif.out_short     <= 1'b0;
            cif.out_short_amt <= 16'd0;
            cif.out_error     <= 1'b0;
        end else begin
            inv_1   <= inv_update(inv_1,   cif.in_refill ? cif.in_refill_1   : 8'd0, dec_1);
            inv_05  <= inv_update(inv_05,  cif.in_refill ? cif.in_refill_05  : 8'd0, dec_05);
            inv_025 <= inv_update(inv_025, cif.in_refill ? cif.in_refill_025 : 8'd0, dec_025);
            cif.out_eject_1   <= (state == EJECT) && (coin == COIN_1);
            cif.out_eject_05  <= (state == EJECT) && (coin == COIN_05);
            cif.out_eject_025 <= (state == EJECT) && (coin == COIN_025);
            cif.out_busy      <= state inside {SEL, EJECT, REL, DONE};
            cif.out_done      <= (state == DONE);
            if (state == IDLE && cif.in_load) begin
                cif.out_short <= 1'b0;
            end else if (state == DONE) begin
                cif.out_short     <= (rem != 16'd0);
                cif.out_short_amt <= rem;
            end
            if (state == EJECT && state_nxt == FAULT) cif.out_error <= 1'b1;
        end
    end

    assign cif.out_inv_1   = inv_1;
    assign cif.out_inv_05  = inv_05;
    assign cif.out_inv_025 = inv_025;
endmodule
